// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush generator for the 5-stage core (IF, ID, EX, MEM, WB).
// Stalls and branch redirects are purely combinational. Exceptions go
// through a small FSM that empties the pipe and waits out an outstanding
// fetch before it redirects IF.
module pipeline_hazard_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int FLUSH_HOLD = 1,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            stall_req,
  input  logic                  exc_req,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic                  branch_req,
  input  logic [ADDR_WIDTH-1:0] branch_pc,
  output logic [4:0]            stall,
  output logic [4:0]            flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [PERF_WIDTH-1:0] stall_cycles
);

  localparam int CW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  typedef enum logic [1:0] {S_RUN, S_WAIT_IF, S_REDIRECT} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           hold_q, hold_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [PERF_WIDTH-1:0]   perf_q;
  logic [4:0]              stall_rule;

  // A stalled stage freezes every stage behind it; WB never stalls.
  for (genvar g = 0; g < 4; g++) begin : g_stall
    assign stall_rule[g] = |stall_req[3:g];
  end
  assign stall_rule[4] = 1'b0;

  // Next-state and all control outputs; reset holds the pipe flushed.
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    pc_d           = pc_q;
    stall          = 5'b00000;
    flush          = 5'b00000;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      flush = 5'b11111;
    end else begin
      case (state_q)
        S_RUN: begin
          if (exc_req) begin
            flush   = 5'b11111;
            pc_d    = exc_pc;
            hold_d  = CW'(FLUSH_HOLD - 1);
            state_d = stall_req[0] ? S_WAIT_IF : S_REDIRECT;
          end else if (branch_req && !stall_rule[2]) begin
            // EX not stalled, so only IF/ID could be; both get squashed.
            flush          = 5'b00011;
            stall          = stall_rule & 5'b11100;
            redirect_valid = 1'b1;
            redirect_pc    = branch_pc;
          end else begin
            stall = stall_rule;
          end
        end
        S_WAIT_IF: begin
          // IF keeps its outstanding fetch alive until memory answers.
          flush = 5'b11111;
          stall = 5'b00001;
          if (!stall_req[0]) state_d = S_REDIRECT;
        end
        S_REDIRECT: begin
          flush          = 5'b11111;
          redirect_valid = 1'b1;
          redirect_pc    = pc_q;
          if (hold_q == '0) state_d = S_RUN;
          else              hold_d  = hold_q - 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // FSM, hold counter and latched exception target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      hold_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pc_q    <= pc_d;
    end
  end

  // Free-running count of cycles with any stage stalled; wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        perf_q <= '0;
    else if (|stall) perf_q <= perf_q + 1'b1;
  end

  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios pinned with literal
// values, then randomized traffic checked every cycle against a mode-level
// model of the hazard controller.
module tb_pipeline_hazard_ctrl;
  localparam int AW = 32;
  localparam int FH = 2;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    stall_req = '0;
  logic          exc_req = 1'b0;
  logic [AW-1:0] exc_pc = '0;
  logic          branch_req = 1'b0;
  logic [AW-1:0] branch_pc = '0;
  logic [4:0]    stall, flush;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [PW-1:0] stall_cycles;

  int n_chk = 0;
  int n_err = 0;

  // model: 0 = running, 1 = waiting on fetch, 2 = redirecting
  int            m_mode = 0;
  int            m_left = 0;
  logic [AW-1:0] m_pc   = '0;
  int            m_perf = 0;

  pipeline_hazard_ctrl #(.ADDR_WIDTH(AW), .FLUSH_HOLD(FH), .PERF_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .exc_req(exc_req),
    .exc_pc(exc_pc), .branch_req(branch_req), .branch_pc(branch_pc),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Outputs the rules demand for the current model mode and inputs.
  task automatic expect_out(output logic [4:0] es, output logic [4:0] ef,
                            output logic erv, output logic [AW-1:0] epc);
    int k;
    logic [4:0] rule;
    es = 0; ef = 0; erv = 0; epc = 0;
    k = -1;
    for (int i = 0; i < 4; i++) if (stall_req[i]) k = i;
    rule = 0;
    for (int i = 0; i <= k; i++) rule[i] = 1'b1;
    if (!rst) begin
      ef = 5'b11111;
    end else if (m_mode == 0) begin
      if (exc_req) ef = 5'b11111;
      else if (branch_req && !rule[2]) begin
        ef = 5'b00011; erv = 1'b1; epc = branch_pc;
      end else es = rule;
    end else if (m_mode == 1) begin
      ef = 5'b11111; es = 5'b00001;
    end else begin
      ef = 5'b11111; erv = 1'b1; epc = m_pc;
    end
  endtask

  // Model advances on the same edges as the design.
  always @(posedge clk or negedge rst) begin
    logic [4:0] es, ef; logic erv; logic [AW-1:0] epc;
    if (!rst) begin
      m_mode = 0; m_left = 0; m_pc = 0; m_perf = 0;
    end else begin
      expect_out(es, ef, erv, epc);
      if (|es) m_perf = (m_perf + 1) % (1 << PW);
      case (m_mode)
        0: if (exc_req) begin
             m_pc = exc_pc; m_left = FH; m_mode = stall_req[0] ? 1 : 2;
           end
        1: if (!stall_req[0]) m_mode = 2;
        default: begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      endcase
    end
  end

  // One cycle: drive at negedge, then compare every output against the model.
  task automatic cyc(input logic [3:0] sr, input logic e, input logic [AW-1:0] epc_i,
                     input logic b, input logic [AW-1:0] bpc_i);
    logic [4:0] es, ef; logic erv; logic [AW-1:0] epc;
    @(negedge clk);
    stall_req = sr; exc_req = e; exc_pc = epc_i; branch_req = b; branch_pc = bpc_i;
    #2;
    expect_out(es, ef, erv, epc);
    chk("stall", stall, es);
    chk("flush", flush, ef);
    chk("redirect_valid", redirect_valid, erv);
    if (erv || !rst) chk("redirect_pc", redirect_pc, epc);
    chk("stall_cycles", stall_cycles, m_perf[PW-1:0]);
  endtask

  task automatic idle();
    cyc(4'b0000, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    // reset state
    rst = 1'b0;
    idle();
    chk("rst_flush", flush, 5'b11111);
    chk("rst_stall", stall, 5'b00000);
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_perf", stall_cycles, 8'd0);
    @(negedge clk); rst = 1'b1;

    // EX stall for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0100, 1'b0, '0, 1'b0, '0);
      chk("ex_stall_lit", stall, 5'b00111);
      chk("ex_flush_lit", flush, 5'b00000);
    end
    idle();
    chk("perf3_lit", stall_cycles, 8'd3);

    cyc(4'b1001, 1'b0, '0, 1'b0, '0);
    chk("mem_stall_lit", stall, 5'b01111);
    cyc(4'b0001, 1'b0, '0, 1'b0, '0);
    chk("if_stall_lit", stall, 5'b00001);

    // branch redirect, no stalls
    cyc(4'b0000, 1'b0, '0, 1'b1, 32'h8000_0100);
    chk("br_flush_lit", flush, 5'b00011);
    chk("br_rv_lit", redirect_valid, 1'b1);
    chk("br_pc_lit", redirect_pc, 32'h8000_0100);
    idle();
    chk("br_run_lit", flush, 5'b00000);

    // branch while EX stalled is ignored
    cyc(4'b0100, 1'b0, '0, 1'b1, 32'h1234);
    chk("br_stalled_rv_lit", redirect_valid, 1'b0);

    // exception with an outstanding fetch
    cyc(4'b0001, 1'b1, 32'hBFC0_0380, 1'b0, '0);
    chk("exc0_flush_lit", flush, 5'b11111);
    chk("exc0_rv_lit", redirect_valid, 1'b0);
    cyc(4'b0001, 1'b0, '0, 1'b0, '0);
    chk("exc1_rv_lit", redirect_valid, 1'b0);
    chk("exc1_stall_lit", stall, 5'b00001);
    cyc(4'b0000, 1'b0, '0, 1'b0, '0);
    chk("exc2_rv_lit", redirect_valid, 1'b0);
    cyc(4'b0000, 1'b0, '0, 1'b0, '0);
    chk("exc3_rv_lit", redirect_valid, 1'b1);
    chk("exc3_pc_lit", redirect_pc, 32'hBFC0_0380);
    idle();
    idle();
    chk("exc_done_lit", flush, 5'b00000);

    // exception and branch in the same cycle
    cyc(4'b0000, 1'b1, 32'h0000_0180, 1'b1, 32'h8000_0200);
    chk("eb_rv_lit", redirect_valid, 1'b0);
    for (int i = 0; i < FH; i++) begin
      cyc(4'b0000, 1'b0, '0, 1'b1, 32'h8000_0200);
      chk("eb_redir_pc_lit", redirect_pc, 32'h0000_0180);
      chk("eb_flush_lit", flush, 5'b11111);
    end
    idle();
    chk("eb_run_lit", flush, 5'b00000);

    // reset in the middle of WAIT_IF
    cyc(4'b0001, 1'b1, 32'hDEAD_0000, 1'b0, '0);
    cyc(4'b0001, 1'b0, '0, 1'b0, '0);
    #1 rst = 1'b0;
    idle();
    chk("midrst_perf_lit", stall_cycles, 8'd0);
    @(negedge clk); rst = 1'b1;
    idle();
    chk("after_rst_rv_lit", redirect_valid, 1'b0);
    chk("after_rst_flush_lit", flush, 5'b00000);

    // counter wrap at 2^PERF_WIDTH
    for (int i = 0; i < 255; i++) cyc(4'b0010, 1'b0, '0, 1'b0, '0);
    idle();
    chk("perf255_lit", stall_cycles, 8'd255);
    cyc(4'b0010, 1'b0, '0, 1'b0, '0);
    idle();
    chk("perf_wrap_lit", stall_cycles, 8'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] sr;
      logic e, b;
      sr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      e  = ($urandom_range(0, 19) == 0);
      b  = ($urandom_range(0, 4) == 0);
      if (rst && $urandom_range(0, 299) == 0) rst = 1'b0;
      else rst = 1'b1;
      cyc(sr, e, $urandom, b, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
